// File: rtl/noise_lfsr_channel.sv
// Noise channel: period timer clocks a two-tap LFSR whose
// output bit gates a registered volume sample for the mixer.
module noise_lfsr_channel #(
  parameter int LFSR_W    = 15,
  parameter int TIMER_W   = 12,
  parameter int VOL_W     = 4,
  parameter int TAP_LONG  = 1,
  parameter int TAP_SHORT = 6,
  parameter logic [LFSR_W-1:0] SEED =
    {1'b1, {(LFSR_W-1){1'b0}}}
) (
  input  logic               iClk,
  input  logic               iReset_n,
  input  logic               iEnable,
  input  logic               iWrite,
  input  logic [TIMER_W-1:0] iPeriod,
  input  logic               iMode,
  input  logic [VOL_W-1:0]   iVolume,
  input  logic               iMute,
  input  logic               iReseed,
  output logic               oData,
  output logic [VOL_W-1:0]   oSample,
  output logic               oShift,
  output logic [LFSR_W-1:0]  oState
);

  logic [LFSR_W-1:0]  r_lfsr;
  logic [TIMER_W-1:0] r_timer;
  logic [TIMER_W-1:0] r_period;
  logic               r_mode;
  logic [VOL_W-1:0]   r_volume;
  logic [VOL_W-1:0]   r_sample;
  logic               r_shift;

  logic w_fb;
  logic w_zero;
  logic w_do_shift;
  logic w_lock;
  logic w_data;

  // Feedback, shift decision and lock-up detect.
  always_comb begin
    w_fb       = r_lfsr[0] ^
                 (r_mode ? r_lfsr[TAP_SHORT]
                         : r_lfsr[TAP_LONG]);
    w_zero     = (r_timer == '0);
    w_do_shift = iEnable & w_zero;
    w_lock     = (r_lfsr == '0);
    w_data     = ~r_lfsr[0];
  end

  // LFSR: reseed or lock-up recovery beats a shift.
  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) begin
      r_lfsr <= SEED;
    end else if (w_lock || iReseed) begin
      r_lfsr <= SEED;
    end else if (w_do_shift) begin
      r_lfsr <= {w_fb, r_lfsr[LFSR_W-1:1]};
    end
  end

  // Period timer: reload on zero, else count down.
  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) begin
      r_timer <= '0;
    end else if (iEnable) begin
      if (w_zero) r_timer <= r_period;
      else        r_timer <= r_timer - 1'b1;
    end
  end

  // Config registers, written regardless of enable.
  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) begin
      r_period <= '0;
      r_mode   <= 1'b0;
      r_volume <= '0;
    end else if (iWrite) begin
      r_period <= iPeriod;
      r_mode   <= iMode;
      r_volume <= iVolume;
    end
  end

  // Shift strobe and gated sample, one cycle behind.
  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) begin
      r_shift  <= 1'b0;
      r_sample <= '0;
    end else begin
      r_shift  <= w_do_shift & ~iReseed & ~w_lock;
      r_sample <= (w_data & ~iMute) ? r_volume : '0;
    end
  end

  assign oData   = w_data;
  assign oState  = r_lfsr;
  assign oShift  = r_shift;
  assign oSample = r_sample;

endmodule

// File: tb/tb_noise_lfsr_channel.sv
// Directed bench for noise_lfsr_channel: reset, sequence,
// timer spacing, sample gating, reseed and mode switching.
module tb_noise_lfsr_channel;

  logic        clk;
  logic        rst_n;
  logic        en, wr, mode, mute, reseed;
  logic [11:0] period;
  logic [3:0]  vol;
  logic        o_data, o_shift;
  logic [3:0]  o_sample;
  logic [14:0] o_state;

  logic        b_en, b_wr, b_mode;
  logic        b_data, b_shift;
  logic [3:0]  b_sample;
  logic [14:0] b_state;

  int n_checks = 0;
  int n_fail   = 0;

  noise_lfsr_channel u_dut (
    .iClk     (clk),
    .iReset_n (rst_n),
    .iEnable  (en),
    .iWrite   (wr),
    .iPeriod  (period),
    .iMode    (mode),
    .iVolume  (vol),
    .iMute    (mute),
    .iReseed  (reseed),
    .oData    (o_data),
    .oSample  (o_sample),
    .oShift   (o_shift),
    .oState   (o_state)
  );

  noise_lfsr_channel #(.SEED(15'h0001)) u_b (
    .iClk     (clk),
    .iReset_n (rst_n),
    .iEnable  (b_en),
    .iWrite   (b_wr),
    .iPeriod  (12'd0),
    .iMode    (b_mode),
    .iVolume  (4'd0),
    .iMute    (1'b0),
    .iReseed  (1'b0),
    .oData    (b_data),
    .oSample  (b_sample),
    .oShift   (b_shift),
    .oState   (b_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic gaps(input bit tog, input int exp,
                      input string tag);
    int t[3];
    int k;
    t = '{0, 0, 0};
    k = 0;
    for (int c = 0; c < 40 && k < 3; c++) begin
      en = tog ? (c % 2 == 0) : 1'b1;
      tick();
      if (o_shift) begin
        t[k] = c;
        k++;
      end
    end
    chk({tag, "_gap1"}, t[1] - t[0], exp);
    chk({tag, "_gap2"}, t[2] - t[1], exp);
  endtask

  initial begin
    int cnt;
    rst_n = 1'b0;
    en = 0; wr = 0; mode = 0; mute = 0; reseed = 0;
    period = '0; vol = '0;
    b_en = 0; b_wr = 0; b_mode = 0;
    tick();
    tick();
    chk("rst_state", o_state, 15'h4000);
    chk("rst_data", o_data, 1'b1);
    chk("rst_sample", o_sample, 4'h0);
    chk("rst_shift", o_shift, 1'b0);

    rst_n = 1'b1;
    repeat (3) tick();
    chk("idle_state", o_state, 15'h4000);
    chk("idle_shift", o_shift, 1'b0);

    wr = 1; vol = 4'hA; period = 12'd0; mode = 0;
    tick();
    wr = 0;
    chk("wr_no_shift", o_state, 15'h4000);
    chk("wr_old_vol", o_sample, 4'h0);
    tick();
    chk("vol_sample", o_sample, 4'hA);

    en = 1;
    tick();
    chk("shift1_state", o_state, 15'h2000);
    chk("shift1_pulse", o_shift, 1'b1);
    repeat (13) tick();
    chk("shift14_state", o_state, 15'h4001);
    chk("shift14_data", o_data, 1'b0);
    chk("shift14_sample", o_sample, 4'hA);
    tick();
    chk("shift15_state", o_state, 15'h6000);
    chk("lag_sample0", o_sample, 4'h0);
    tick();
    chk("shift16_state", o_state, 15'h3000);
    chk("lag_sampleA", o_sample, 4'hA);
    mute = 1;
    tick();
    chk("mute_on", o_sample, 4'h0);
    mute = 0;
    tick();
    chk("mute_off", o_sample, 4'hA);
    chk("shift18_state", o_state, 15'h0C00);

    en = 0;
    tick();
    chk("freeze_state", o_state, 15'h0C00);
    chk("freeze_shift", o_shift, 1'b0);

    reseed = 1;
    tick();
    reseed = 0;
    chk("reseed_idle", o_state, 15'h4000);

    en = 1;
    cnt = 0;
    for (int i = 0; i < 40000; i++) begin
      tick();
      if (o_shift) cnt++;
      if (o_state == 15'h4000) break;
    end
    chk("long_period", cnt, 32767);

    en = 0; wr = 1; period = 12'd2;
    tick();
    wr = 0;
    gaps(1'b0, 3, "p2");
    gaps(1'b1, 6, "p2_half");

    en = 0; wr = 1; period = 12'd0;
    tick();
    wr = 0;
    en = 1;
    repeat (4) tick();
    chk("pre_reseed_shift", o_shift, 1'b1);
    reseed = 1;
    tick();
    reseed = 0;
    chk("reseed_state", o_state, 15'h4000);
    chk("reseed_shift", o_shift, 1'b0);
    repeat (8) tick();
    chk("walk_state", o_state, 15'h0040);
    wr = 1; mode = 1;
    tick();
    wr = 0;
    chk("wr_old_tap", o_state, 15'h0020);
    repeat (5) tick();
    chk("new_tap", o_state, 15'h0001);

    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("mid_rst_state", o_state, 15'h4000);
    chk("mid_rst_shift", o_shift, 1'b0);
    chk("mid_rst_sample", o_sample, 4'h0);
    en = 0;
    tick();
    rst_n = 1'b1;
    tick();
    en = 1;
    tick();
    chk("post_rst_state", o_state, 15'h2000);
    chk("post_rst_vol", o_sample, 4'h0);
    en = 0;

    b_wr = 1; b_mode = 1;
    tick();
    b_wr = 0;
    b_en = 1;
    cnt = 0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (b_shift) cnt++;
      if (b_state == 15'h0001) break;
    end
    chk("short_period", cnt, 93);
    b_en = 0;

    $display("TB_RESULT checks=%0d failures=%0d",
             n_checks, n_fail);
    $finish;
  end

endmodule
